piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in/serial-out framing stage that sits directly upstream of the SISO shift register and drives its serial input. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock. A one-word holding buffer lets consecutive words stream with no idle bit between them. A per-bit valid flag and an end-of-word pulse let downstream stages frame the bit stream.

Parameters:
WIDTH, 8, bits per word (WIDTH >= 2)
MSB_FIRST, 1, 1 = bit WIDTH-1 shifted out first; 0 = bit 0 first

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset (rst=0 at a rising edge resets)
pdata  input  WIDTH  parallel word, sampled only on a handshake
load_valid  input  1  producer has a word on pdata
load_ready  output  1  block can accept a word this cycle
so  output  1  serial data out, feeds the SISO si input
so_valid  output  1  so carries a real data bit this cycle
busy  output  1  shifter or holding buffer occupied
done  output  1  one-cycle pulse coinciding with the last bit of a word

Behaviour:
- Reset (rst=0 at an edge): so=0, so_valid=0, done=0, busy=0, load_ready=1, bit counter=0, buffer empty, shifter idle. Any word in flight or buffered is discarded.
- Handshake: a word is accepted at an edge where load_valid=1 and load_ready=1. pdata is ignored otherwise. load_valid may stay high across cycles.
- load_ready = !buffer_full. It is registered and depends only on current state, with no combinational path from load_valid.
- States:
  - IDLE: shifter empty.
  - SHIFT: counter runs from 0 to WIDTH-1.
- IDLE + accept: the word loads straight into the shifter and the state moves to SHIFT. The first bit appears on so with so_valid=1 in the next cycle (latency 1).
- SHIFT: one bit per cycle in the order set by MSB_FIRST. so_valid=1 for exactly WIDTH consecutive cycles per word.
- SHIFT + accept while the buffer is empty: the word goes into the buffer and load_ready drops the next cycle.
- Last-bit cycle (counter=WIDTH-1): done=1.
  - If the buffer is full: the buffer moves to the shifter, the next word's first bit follows in the next cycle with no gap, the buffer empties, and load_ready rises.
  - Else, if an accept occurs in this same cycle: that word loads straight into the shifter, with no gap and the buffer staying empty.
  - Else: return to IDLE.
- IDLE outputs: so=0, so_valid=0, done=0.
- busy = (state==SHIFT) | buffer_full.
- The counter wraps to 0 on every word boundary. There is no overflow state.
- Word order is preserved strictly: shifter first, then buffer.

Test Plan:
1. WIDTH=8, MSB_FIRST=1: after reset, single accept of 8'hA5 at cycle 0 -> so=1,0,1,0,0,1,0,1 on cycles 1–8, so_valid high on cycles 1–8 only, done high on cycle 8 only, busy low from cycle 9.
2. Back-to-back: load_valid held high with 8'hA5 then 8'h3C -> 16 contiguous so_valid cycles giving 10100101 00111100, and done pulses at cycles 8 and 16.
3. Back-pressure: three words offered continuously -> load_ready low from the cycle after the 2nd accept until the cycle after the first word's last bit. The 3rd word's bits follow word 2 with no gap.
4. Reset mid-word: rst=0 at bit 4 of 8'hFF while a word is buffered -> next cycle so=0, so_valid=0, load_ready=1, busy=0. No stale bits appear after reset is released.
5. MSB_FIRST=0 with 8'h01 -> so=1,0,0,0,0,0,0,0.
6. Same-cycle refill: new word offered exactly on the last-bit cycle while the buffer is empty -> accepted, first bit on the next cycle, no so_valid gap.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Load-side handshake between a word producer and the PISO serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] pdata;
  logic             load_valid;
  logic             load_ready;

  modport master (output pdata, output load_valid, input load_ready);
  modport slave  (input pdata, input load_valid, output load_ready);
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out framer: one bit per clock, with a one-word holding buffer so
// consecutive words stream without an idle bit between them.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer_if.slave   ld,
  output logic               so,
  output logic               so_valid,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [WIDTH-1:0]  buf_q, buf_d;
  logic              full_q, full_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]  pdata;
  logic [WIDTH-1:0]  shifted;
  logic              accept;
  logic              last;
  logic              so_bit;

  assign pdata   = ld.pdata;
  // load_ready comes straight from the buffer flag, so accept has no loop through ready.
  assign accept  = ld.load_valid & ~full_q;
  assign last    = (cnt_q == CntW'(WIDTH - 1));
  assign shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
  assign so_bit  = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    buf_d   = buf_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sreg_d  = pdata;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (!last) begin
          sreg_d = shifted;
          cnt_d  = cnt_q + CntW'(1);
          if (accept) begin
            buf_d  = pdata;
            full_d = 1'b1;
          end
        end else begin
          // Word boundary: buffered word has priority to keep strict ordering.
          cnt_d = '0;
          if (full_q) begin
            sreg_d = buf_q;
            full_d = 1'b0;
          end else if (accept) begin
            sreg_d = pdata;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
    end
  end

  assign so_valid      = (state_q == StShift);
  assign so            = so_valid & so_bit;
  assign done          = so_valid & last;
  assign busy          = so_valid | full_q;
  assign ld.load_ready = ~full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance on shared clk/rst.
module tb_piso_serializer;

  logic clk;
  logic rst;
  logic so_m, so_valid_m, busy_m, done_m;
  logic so_l, so_valid_l, busy_l, done_l;
  int   errors;
  int   checks;

  piso_serializer_if #(.WIDTH(8)) ifm ();
  piso_serializer_if #(.WIDTH(8)) ifl ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk      (clk),
    .rst      (rst),
    .ld       (ifm.slave),
    .so       (so_m),
    .so_valid (so_valid_m),
    .busy     (busy_m),
    .done     (done_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk      (clk),
    .rst      (rst),
    .ld       (ifl.slave),
    .so       (so_l),
    .so_valid (so_valid_l),
    .busy     (busy_l),
    .done     (done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifm.load_valid = 1'b0; ifm.pdata = '0;
    ifl.load_valid = 1'b0; ifl.pdata = '0;
    tick(); tick();
    checks++;
    if ({so_m, so_valid_m, done_m, busy_m, ifm.load_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_m: {so,so_valid,done,busy,ready} got %b want 00001",
               {so_m, so_valid_m, done_m, busy_m, ifm.load_ready});
    end
    checks++;
    if ({so_l, so_valid_l, done_l, busy_l, ifl.load_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_l: {so,so_valid,done,busy,ready} got %b want 00001",
               {so_l, so_valid_l, done_l, busy_l, ifl.load_ready});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hA5;
    ifm.pdata = w; ifm.load_valid = 1'b1;
    tick();
    ifm.load_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if ({so_m, so_valid_m, done_m, busy_m} !== {w[8-c], 1'b1, (c == 8), 1'b1}) begin
        errors++;
        $display("FAIL single c%0d: {so,vld,done,busy} got %b want %b", c,
                 {so_m, so_valid_m, done_m, busy_m}, {w[8-c], 1'b1, (c == 8), 1'b1});
      end
      tick();
    end
    checks++;
    if ({so_m, so_valid_m, done_m, busy_m} !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle: {so,vld,done,busy} got %b want 0000",
               {so_m, so_valid_m, done_m, busy_m});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    s = 16'hA53C;
    ifm.pdata = 8'hA5; ifm.load_valid = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      if (c == 1) ifm.pdata = 8'h3C;
      else        ifm.load_valid = 1'b0;
      checks++;
      if ({so_m, so_valid_m, done_m} !== {s[16-c], 1'b1, (c == 8 || c == 16)}) begin
        errors++;
        $display("FAIL b2b c%0d: {so,vld,done} got %b want %b", c,
                 {so_m, so_valid_m, done_m}, {s[16-c], 1'b1, (c == 8 || c == 16)});
      end
      tick();
    end
    checks++;
    if ({so_valid_m, busy_m} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle: {vld,busy} got %b want 00", {so_valid_m, busy_m});
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] s;
    logic        rdy_exp;
    s = 24'hC35A96;
    ifm.pdata = 8'hC3; ifm.load_valid = 1'b1;
    tick();
    for (int c = 1; c <= 24; c++) begin
      if (c == 1)       ifm.pdata = 8'h5A;
      else if (c == 2)  ifm.pdata = 8'h96;
      else if (c == 10) ifm.load_valid = 1'b0;
      rdy_exp = !((c >= 2 && c <= 8) || (c >= 10 && c <= 16));
      checks++;
      if ({so_m, so_valid_m, done_m, busy_m, ifm.load_ready} !==
          {s[24-c], 1'b1, (c == 8 || c == 16 || c == 24), 1'b1, rdy_exp}) begin
        errors++;
        $display("FAIL bp c%0d: {so,vld,done,busy,ready} got %b want %b", c,
                 {so_m, so_valid_m, done_m, busy_m, ifm.load_ready},
                 {s[24-c], 1'b1, (c == 8 || c == 16 || c == 24), 1'b1, rdy_exp});
      end
      tick();
    end
    checks++;
    if ({so_valid_m, busy_m, ifm.load_ready} !== 3'b001) begin
      errors++;
      $display("FAIL bp_idle: {vld,busy,ready} got %b want 001",
               {so_valid_m, busy_m, ifm.load_ready});
    end
  endtask

  task automatic test_reset_mid();
    ifm.pdata = 8'hFF; ifm.load_valid = 1'b1;
    tick();
    ifm.pdata = 8'h81;
    tick();
    ifm.load_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({so_m, so_valid_m, busy_m, ifm.load_ready} !== 4'b1110) begin
      errors++;
      $display("FAIL rstmid_pre: {so,vld,busy,ready} got %b want 1110",
               {so_m, so_valid_m, busy_m, ifm.load_ready});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({so_m, so_valid_m, done_m, busy_m, ifm.load_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL rstmid_post: {so,vld,done,busy,ready} got %b want 00001",
               {so_m, so_valid_m, done_m, busy_m, ifm.load_ready});
    end
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if ({so_m, so_valid_m, busy_m} !== 3'b000) begin
        errors++;
        $display("FAIL rstmid_stale c%0d: {so,vld,busy} got %b want 000", c,
                 {so_m, so_valid_m, busy_m});
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    w = 8'h01;
    ifl.pdata = w; ifl.load_valid = 1'b1;
    tick();
    ifl.load_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if ({so_l, so_valid_l, done_l} !== {w[c-1], 1'b1, (c == 8)}) begin
        errors++;
        $display("FAIL lsb c%0d: {so,vld,done} got %b want %b", c,
                 {so_l, so_valid_l, done_l}, {w[c-1], 1'b1, (c == 8)});
      end
      tick();
    end
    checks++;
    if ({so_valid_l, busy_l} !== 2'b00) begin
      errors++;
      $display("FAIL lsb_idle: {vld,busy} got %b want 00", {so_valid_l, busy_l});
    end
  endtask

  task automatic test_refill();
    logic [15:0] s;
    s = 16'h5AC3;
    ifm.pdata = 8'h5A; ifm.load_valid = 1'b1;
    tick();
    ifm.load_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 8) begin
        ifm.pdata = 8'hC3; ifm.load_valid = 1'b1;
      end else begin
        ifm.load_valid = 1'b0;
      end
      checks++;
      if ({so_m, so_valid_m, done_m, ifm.load_ready} !==
          {s[16-c], 1'b1, (c == 8 || c == 16), 1'b1}) begin
        errors++;
        $display("FAIL refill c%0d: {so,vld,done,ready} got %b want %b", c,
                 {so_m, so_valid_m, done_m, ifm.load_ready},
                 {s[16-c], 1'b1, (c == 8 || c == 16), 1'b1});
      end
      tick();
    end
    checks++;
    if ({so_valid_m, busy_m} !== 2'b00) begin
      errors++;
      $display("FAIL refill_idle: {vld,busy} got %b want 00", {so_valid_m, busy_m});
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_lsb_first();
    test_refill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
